// File: rtl/handshake_data_synchronizer_pkg.sv
// Shared encodings and defaults for the req/ack handshake data synchronizer.
`timescale 1ns/1ps
package handshake_data_synchronizer_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACKLOW = 2'd2
    } src_state_e;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_VALID = 2'd1,
        D_ACK   = 2'd2
    } dst_state_e;

endpackage

// File: rtl/handshake_data_synchronizer_sync.sv
// Multi-flop level synchronizer with asynchronous, active-low reset to INIT.
`timescale 1ns/1ps
module handshake_data_synchronizer_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ff <= {STAGES{INIT}};
        else         ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/handshake_data_synchronizer.sv
// 4-phase req/ack word transfer from i_in_clk to i_out_clk over a held data bus.
`timescale 1ns/1ps
module handshake_data_synchronizer
    import handshake_data_synchronizer_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                  i_in_clk,
    input  logic                  i_in_arst_n,
    input  logic                  i_out_clk,
    input  logic                  i_out_arst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data
);

    src_state_e            src_state;
    dst_state_e            dst_state;
    logic                  req, ack;
    logic                  req_sync, ack_sync;
    logic [DATA_WIDTH-1:0] hold;

    handshake_data_synchronizer_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_req_sync (
        .clk    (i_out_clk),
        .arst_n (i_out_arst_n),
        .d      (req),
        .q      (req_sync)
    );

    // Ack path resets to 1 so a source reset cannot open o_in_ready until a
    // genuine low ack has crossed, which keeps a stale ack from a reset
    // mid-transfer out of the next handshake.
    handshake_data_synchronizer_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ack_sync (
        .clk    (i_in_clk),
        .arst_n (i_in_arst_n),
        .d      (ack),
        .q      (ack_sync)
    );

    // Both terms are flops, so ready is glitch-free.
    assign o_in_ready = (src_state == S_IDLE) && !ack_sync;

    always_ff @(posedge i_in_clk or negedge i_in_arst_n) begin
        if (!i_in_arst_n) begin
            src_state <= S_IDLE;
            req       <= 1'b0;
            hold      <= '0;
        end else begin
            case (src_state)
                S_IDLE: begin
                    if (i_in_valid && !ack_sync) begin
                        hold      <= i_in_data;
                        req       <= 1'b1;
                        src_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_sync) begin
                        req       <= 1'b0;
                        src_state <= S_ACKLOW;
                    end
                end
                S_ACKLOW: begin
                    if (!ack_sync) src_state <= S_IDLE;
                end
                default: begin
                    req       <= 1'b0;
                    src_state <= S_IDLE;
                end
            endcase
        end
    end

    // hold is quasi-static whenever req_sync is high, so it is sampled directly.
    always_ff @(posedge i_out_clk or negedge i_out_arst_n) begin
        if (!i_out_arst_n) begin
            dst_state   <= D_IDLE;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            ack         <= 1'b0;
        end else begin
            case (dst_state)
                D_IDLE: begin
                    if (req_sync) begin
                        o_out_data  <= hold;
                        o_out_valid <= 1'b1;
                        dst_state   <= D_VALID;
                    end
                end
                D_VALID: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        ack         <= 1'b1;
                        dst_state   <= D_ACK;
                    end
                end
                D_ACK: begin
                    if (!req_sync) begin
                        ack       <= 1'b0;
                        dst_state <= D_IDLE;
                    end
                end
                default: begin
                    o_out_valid <= 1'b0;
                    ack         <= 1'b0;
                    dst_state   <= D_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_data_synchronizer.sv
// Directed bench for handshake_data_synchronizer: transfers, backpressure, streams, resets.
`timescale 1ns/1ps
module tb_handshake_data_synchronizer;

    logic       i_in_clk, i_out_clk;
    logic       i_in_arst_n, i_out_arst_n;
    logic       i_in_valid, o_in_ready;
    logic [7:0] i_in_data;
    logic       o_out_valid, i_out_ready;
    logic [7:0] o_out_data;

    real in_half  = 5.0;
    real out_half = 13.5;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         vhigh = 0;

    handshake_data_synchronizer #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_in_clk     (i_in_clk),
        .i_in_arst_n  (i_in_arst_n),
        .i_out_clk    (i_out_clk),
        .i_out_arst_n (i_out_arst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_data    (i_in_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data)
    );

    initial begin
        i_in_clk = 1'b0;
        forever #(in_half) i_in_clk = ~i_in_clk;
    end

    initial begin
        i_out_clk = 1'b0;
        forever #(out_half) i_out_clk = ~i_out_clk;
    end

    // Consumption monitor; inputs on the out side change 1 ns after posedge.
    always @(negedge i_out_clk) begin
        if (o_out_valid && i_out_ready) rx_q.push_back(o_out_data);
        if (o_out_valid) vhigh <= vhigh + 1;
    end

    task automatic wait_ready(input int budget, input string tag);
        int n = 0;
        while (n < budget) begin
            @(negedge i_in_clk);
            if (o_in_ready) break;
            n++;
        end
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: o_in_ready=%0b after %0d in cycles, required 1", tag, o_in_ready, budget);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input string tag);
        @(posedge i_in_clk); #1;
        i_in_valid = 1'b1;
        i_in_data  = d;
        wait_ready(2000, tag);
        @(posedge i_in_clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic set_out_ready(input logic v);
        @(posedge i_out_clk); #1;
        i_out_ready = v;
    endtask

    task automatic test_reset();
        #50;
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b, required 0", o_out_valid);
        end
        checks++;
        if (o_out_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %02h, required 00", o_out_data);
        end
        @(negedge i_in_clk);  i_in_arst_n  = 1'b1;
        @(negedge i_out_clk); i_out_arst_n = 1'b1;
        wait_ready(20, "reset_ready");
        checks++;
        if (rx_q.size() != 0) begin
            errors++; $display("FAIL reset_no_delivery: got %0d words, required 0", rx_q.size());
        end
    endtask

    task automatic test_single();
        int base = rx_q.size();
        int vb;
        set_out_ready(1'b1);
        vb = vhigh;
        send_word(8'hA5, "single_accept");
        @(negedge i_in_clk);
        checks++;
        if (o_in_ready !== 1'b0) begin
            errors++; $display("FAIL single_busy: o_in_ready=%0b, required 0", o_in_ready);
        end
        wait_ready(2000, "single_ready_return");
        checks++;
        if (rx_q.size() - base != 1) begin
            errors++; $display("FAIL single_count: got %0d words, required 1", rx_q.size() - base);
        end else begin
            checks++;
            if (rx_q[base] !== 8'hA5) begin
                errors++; $display("FAIL single_data: got %02h, required a5", rx_q[base]);
            end
        end
        checks++;
        if (vhigh - vb != 1) begin
            errors++; $display("FAIL single_pulse: valid high %0d cycles, required 1", vhigh - vb);
        end
    endtask

    task automatic test_backpressure();
        int base = rx_q.size();
        int n = 0;
        int bad_v = 0, bad_d = 0, bad_r = 0;
        set_out_ready(1'b0);
        send_word(8'h3C, "bp_accept");
        while (n < 200 && o_out_valid !== 1'b1) begin
            @(negedge i_out_clk);
            n++;
        end
        checks++;
        if (o_out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid_rise: o_out_valid=%0b, required 1", o_out_valid);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge i_out_clk);
            if (o_out_valid !== 1'b1) bad_v++;
            if (o_out_data !== 8'h3C) bad_d++;
            if (o_in_ready !== 1'b0)  bad_r++;
        end
        checks++;
        if (bad_v != 0) begin errors++; $display("FAIL bp_valid_hold: %0d bad cycles, required 0", bad_v); end
        checks++;
        if (bad_d != 0) begin errors++; $display("FAIL bp_data_hold: %0d bad cycles (last %02h), required 0 (3c)", bad_d, o_out_data); end
        checks++;
        if (bad_r != 0) begin errors++; $display("FAIL bp_in_ready_low: %0d bad cycles, required 0", bad_r); end
        set_out_ready(1'b1);
        wait_ready(2000, "bp_ready_return");
        checks++;
        if (rx_q.size() - base != 1 || rx_q[rx_q.size()-1] !== 8'h3C) begin
            errors++; $display("FAIL bp_consume: got %0d words (last %02h), required 1 (3c)",
                               rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
    endtask

    task automatic test_stream(input real ih, input real oh, input string tag);
        int base;
        int n = 0;
        int bad = 0;
        in_half  = ih;
        out_half = oh;
        repeat (5) @(posedge i_in_clk);
        set_out_ready(1'b1);
        repeat (5) @(posedge i_out_clk);
        base = rx_q.size();
        @(posedge i_in_clk); #1;
        i_in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            i_in_data = 8'(i);
            wait_ready(2000, tag);
            @(posedge i_in_clk); #1;
        end
        i_in_valid = 1'b0;
        while (n < 5000 && rx_q.size() - base < 256) begin
            @(negedge i_out_clk);
            n++;
        end
        repeat (20) @(negedge i_out_clk);
        checks++;
        if (rx_q.size() - base != 256) begin
            errors++; $display("FAIL %s_count: got %0d words, required 256", tag, rx_q.size() - base);
        end
        for (int i = 0; i < 256 && base + i < rx_q.size(); i++)
            if (rx_q[base+i] !== 8'(i)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL %s_order: %0d words out of order, required 0", tag, bad);
        end
        in_half  = 5.0;
        out_half = 13.5;
        repeat (5) @(posedge i_out_clk);
    endtask

    task automatic test_ignored_input();
        int base = rx_q.size();
        @(posedge i_in_clk); #1;
        i_in_valid = 1'b1;
        i_in_data  = 8'h5A;
        wait_ready(2000, "ign_accept");
        @(posedge i_in_clk); #1;
        i_in_data = 8'hC3;
        for (int i = 0; i < 2000; i++) begin
            @(negedge i_in_clk);
            if (o_in_ready) break;
            i_in_data = ~i_in_data;
        end
        i_in_valid = 1'b0;
        repeat (30) @(posedge i_in_clk);
        checks++;
        if (rx_q.size() - base != 1 || rx_q[rx_q.size()-1] !== 8'h5A) begin
            errors++; $display("FAIL ignored_input: got %0d words (last %02h), required 1 (5a)",
                               rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
    endtask

    task automatic test_src_reset();
        int base = rx_q.size();
        int n11 = 0;
        send_word(8'h77, "srst_accept");
        i_in_arst_n = 1'b0;
        repeat (3) @(posedge i_in_clk);
        #1 i_in_arst_n = 1'b1;
        wait_ready(2000, "srst_ready_return");
        repeat (30) @(posedge i_in_clk);
        send_word(8'h11, "srst_next_accept");
        wait_ready(2000, "srst_next_ready");
        for (int i = base; i < rx_q.size(); i++) if (rx_q[i] === 8'h11) n11++;
        checks++;
        if (n11 != 1) begin
            errors++; $display("FAIL srst_next_once: 11 seen %0d times, required 1", n11);
        end
        checks++;
        if (rx_q.size() - base > 2) begin
            errors++; $display("FAIL srst_extra: got %0d words, required at most 2", rx_q.size() - base);
        end
    endtask

    task automatic test_dst_reset();
        int base = rx_q.size();
        int n = 0;
        int n44 = 0;
        set_out_ready(1'b0);
        send_word(8'h44, "drst_accept");
        while (n < 200 && o_out_valid !== 1'b1) begin
            @(negedge i_out_clk);
            n++;
        end
        @(posedge i_out_clk); #1;
        i_out_arst_n = 1'b0;
        #1;
        checks++;
        if (o_out_valid !== 1'b0) begin
            errors++; $display("FAIL drst_valid_drop: got %0b, required 0", o_out_valid);
        end
        repeat (2) @(posedge i_out_clk);
        #1 i_out_arst_n = 1'b1;
        set_out_ready(1'b1);
        wait_ready(2000, "drst_ready_return");
        for (int i = base; i < rx_q.size(); i++) if (rx_q[i] === 8'h44) n44++;
        checks++;
        if (n44 != 1) begin
            errors++; $display("FAIL drst_redeliver: 44 seen %0d times, required 1", n44);
        end
        send_word(8'h22, "drst_next_accept");
        wait_ready(2000, "drst_next_ready");
        checks++;
        if (rx_q.size() - base != 2 || rx_q[rx_q.size()-1] !== 8'h22) begin
            errors++; $display("FAIL drst_next: got %0d words (last %02h), required 2 (22)",
                               rx_q.size() - base, rx_q[rx_q.size()-1]);
        end
    endtask

    initial begin
        i_in_arst_n  = 1'b0;
        i_out_arst_n = 1'b0;
        i_in_valid   = 1'b0;
        i_in_data    = 8'h00;
        i_out_ready  = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream(5.0, 13.5, "stream_fast_slow");
        test_stream(38.5, 5.0, "stream_slow_fast");
        test_ignored_input();
        test_src_reset();
        test_dst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
